// File: rtl/instr_issue_pkg.sv
// Shared constants and types for the instruction byte assembler / issue path.
// Holds the host byte width, instruction width, NOP encoding and default FIFO depth;
// these are also consumed by the control unit.
package instr_issue_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned INSTR_WIDTH   = 16;
    localparam int unsigned DEFAULT_DEPTH = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP = 16'h0000;

    // Assembler state: waiting for the high byte or for the low byte.
    typedef enum logic {
        ASM_HI = 1'b0,
        ASM_LO = 1'b1
    } asm_state_t;

    // Instruction word as assembled from two host bytes, high byte first.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] hi;
        logic [DATA_WIDTH-1:0] lo;
    } instr_bytes_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: storage, wrapping pointers and occupancy count.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           synchronous clear of pointers and count
//   push, push_data write one entry (ignored when full)
//   pop, pop_data   remove the head entry (ignored when empty); pop_data shows the head
//   full, empty     occupancy flags derived from count
//   count           number of entries held
module instr_fifo
    import instr_issue_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read out.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue stage: assembles host bytes into instructions, queues them and
// issues one per cycle to the control unit when it is not busy.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   byte_in         host byte (first = instruction high byte, second = low byte)
//   byte_valid      byte_in valid this cycle
//   byte_ready      byte accepted this cycle (FIFO not full, no flush, not in reset)
//   flush           synchronous clear of FIFO and assembler
//   ctrl_busy       control unit cannot accept an instruction
//   instruction     issued instruction, NOP when nothing issued
//   instr_valid     instruction is a fresh issue this cycle
//   fifo_count      number of complete instructions queued
//   overflow        sticky flag: byte offered while byte_ready was low
module instr_issue #(
    parameter int unsigned DEPTH       = instr_issue_pkg::DEFAULT_DEPTH,
    parameter int unsigned INSTR_WIDTH = instr_issue_pkg::INSTR_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [instr_issue_pkg::DATA_WIDTH-1:0]  byte_in,
    input  logic                                    byte_valid,
    output logic                                    byte_ready,
    input  logic                                    flush,
    input  logic                                    ctrl_busy,
    output logic [INSTR_WIDTH-1:0]                  instruction,
    output logic                                    instr_valid,
    output logic [$clog2(DEPTH):0]                  fifo_count,
    output logic                                    overflow
);

    import instr_issue_pkg::*;

    asm_state_t            state;
    asm_state_t            state_next;
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] hi_next;
    logic                  transfer_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  overflow_c;
    instr_bytes_t          asm_word;
    logic [INSTR_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;

    // Ready depends only on registered occupancy plus the flush/reset inputs.
    assign byte_ready = !rst && !flush && !full;
    assign transfer_c = byte_valid && byte_ready;
    assign overflow_c = byte_valid && !byte_ready && !flush;
    assign pop_c      = !empty && !ctrl_busy && !flush && !rst;

    always_comb begin
        asm_word.hi = hi_reg;
        asm_word.lo = byte_in;
    end

    // Assembler next-state: HI captures the high byte, LO completes and pushes.
    always_comb begin
        state_next = state;
        hi_next    = hi_reg;
        push_c     = 1'b0;
        case (state)
            ASM_HI: begin
                if (transfer_c) begin
                    hi_next    = byte_in;
                    state_next = ASM_LO;
                end
            end
            ASM_LO: begin
                if (transfer_c) begin
                    push_c     = 1'b1;
                    state_next = ASM_HI;
                end
            end
            default: state_next = ASM_HI;
        endcase
        if (flush) state_next = ASM_HI;
    end

    // Assembler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ASM_HI;
            hi_reg <= '0;
        end else begin
            state  <= state_next;
            hi_reg <= hi_next;
        end
    end

    // Issue register: valid for exactly the cycle after each pop, NOP otherwise.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instruction <= INSTR_WIDTH'(NOP);
            instr_valid <= 1'b0;
        end else if (pop_c) begin
            instruction <= head;
            instr_valid <= 1'b1;
        end else begin
            instruction <= INSTR_WIDTH'(NOP);
            instr_valid <= 1'b0;
        end
    end

    // Sticky overflow; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)             overflow <= 1'b0;
        else if (overflow_c) overflow <= 1'b1;
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_c),
        .push_data (INSTR_WIDTH'(asm_word)),
        .pop       (pop_c),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule
